// File: rtl/pattern_adc_pkg.sv
// Shared types and helpers for the synthetic pattern ADC source.
// PATTERN_ADC_CHECKSUM_EN adds one XOR checksum byte to every frame.
package pattern_adc_pkg;

  typedef enum logic [1:0] {
    MODE_CONST   = 2'd0,
    MODE_COUNT   = 2'd1,
    MODE_RAMP    = 2'd2,
    MODE_CHAN_ID = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SEND
  } state_t;

`ifdef PATTERN_ADC_CHECKSUM_EN
  localparam int CHECKSUM_BYTES = 1;
`else
  localparam int CHECKSUM_BYTES = 0;
`endif

  function automatic int frame_bytes(input int sample_bytes, input int num_channels);
    return sample_bytes * num_channels + CHECKSUM_BYTES;
  endfunction

  localparam int FRAME_BYTES = frame_bytes(4, 2);

  // Full 32-bit sample; the caller only ever selects the low SAMPLE_BYTES bytes.
  function automatic logic [31:0] sample_value(input mode_t mode, input logic [31:0] f,
                                               input logic [2:0] c, input logic [31:0] nc,
                                               input logic [31:0] const_pattern);
    logic [31:0] value;
    case (mode)
      MODE_CONST: value = const_pattern;
      MODE_COUNT: value = f;
      MODE_RAMP:  value = f * nc + {29'd0, c};
      default:    value = {5'd0, c, f[23:0]};
    endcase
    return value;
  endfunction

endpackage

// File: rtl/pattern_adc_tick.sv
// Free-running sample-period divider: one-cycle tick every CLK_DIV clocks.
module pattern_adc_tick #(
  parameter int CLK_DIV = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/pattern_adc_source.sv
// Synthetic multi-channel ADC front end writing sample frames into a byte FIFO.
// Define PATTERN_ADC_CHECKSUM_EN to append an XOR checksum byte to each frame.
module pattern_adc_source
  import pattern_adc_pkg::*;
#(
  parameter int          SAMPLE_BYTES  = 4,
  parameter int          NUM_CHANNELS  = 2,
  parameter int          CLK_DIV       = 256,
  parameter int          ADDR_WIDTH    = 11,
  parameter logic [31:0] CONST_PATTERN = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  fifo_clk,
  output logic [7:0]            fifo_data,
  output logic                  fifo_write,
  input  logic [ADDR_WIDTH-1:0] fifo_addr_in,
  input  logic [ADDR_WIDTH-1:0] fifo_addr_out,
  input  logic                  direction,
  input  logic [1:0]            mode,
  output logic                  overflow,
  input  logic                  clear_ovf,
  output logic [15:0]           drop_count
);

  localparam int         FRAME_LEN = frame_bytes(SAMPLE_BYTES, NUM_CHANNELS);
  localparam logic [2:0] LAST_CH   = 3'(NUM_CHANNELS - 1);
  localparam logic [1:0] LAST_BYTE = 2'(SAMPLE_BYTES - 1);

  logic tick;

  pattern_adc_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i  (clk),
    .rst_i  (reset),
    .tick_o (tick)
  );

  state_t      state_q, state_d;
  mode_t       mode_q, mode_d;
  logic [31:0] frame_q, frame_d;
  logic [2:0]  ch_q, ch_d;
  logic [1:0]  bi_q, bi_d;
  logic [7:0]  csum_q, csum_d;
  logic        csum_phase_q, csum_phase_d;
  logic        ovf_q, ovf_d;
  logic [15:0] drop_q, drop_d;

  logic [ADDR_WIDTH-1:0] used, free;
  logic                  space_ok;
  logic                  drop_evt;
  logic [31:0]           sample;
  logic [7:0]            sample_byte;

  // All-ones minus used is just the bitwise complement; modular wrap comes for free.
  assign used     = fifo_addr_in - fifo_addr_out;
  assign free     = ~used;
  assign space_ok = 32'(free) >= 32'(FRAME_LEN);

  assign sample      = sample_value(mode_q, frame_q, ch_q, 32'(NUM_CHANNELS), CONST_PATTERN);
  assign sample_byte = sample[{bi_q, 3'b000} +: 8];

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    frame_d      = frame_q;
    ch_d         = ch_q;
    bi_d         = bi_q;
    csum_d       = csum_q;
    csum_phase_d = csum_phase_q;
    ovf_d        = ovf_q;
    drop_d       = drop_q;
    drop_evt     = 1'b0;
    fifo_write   = 1'b0;
    fifo_data    = 8'h00;

    case (state_q)
      IDLE: begin
        if (tick && direction) begin
          state_d = CHECK;
          mode_d  = mode_t'(mode);
        end
      end
      CHECK: begin
        if (space_ok) begin
          state_d      = SEND;
          ch_d         = 3'd0;
          bi_d         = 2'd0;
          csum_d       = 8'h00;
          csum_phase_d = 1'b0;
        end else begin
          drop_evt = 1'b1;
          state_d  = IDLE;
        end
      end
      SEND: begin
        fifo_write = 1'b1;
        if (csum_phase_q) begin
          fifo_data = csum_q;
          state_d   = IDLE;
          frame_d   = frame_q + 32'd1;
        end else begin
          fifo_data = sample_byte;
          csum_d    = csum_q ^ sample_byte;
          if (bi_q == LAST_BYTE) begin
            bi_d = 2'd0;
            if (ch_q == LAST_CH) begin
`ifdef PATTERN_ADC_CHECKSUM_EN
              csum_phase_d = 1'b1;
`else
              state_d = IDLE;
              frame_d = frame_q + 32'd1;
`endif
            end else begin
              ch_d = ch_q + 3'd1;
            end
          end else begin
            bi_d = bi_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A tick that arrives while a frame is still in flight is a lost frame.
    if (tick && direction && state_q != IDLE) drop_evt = 1'b1;

    if (drop_evt) begin
      ovf_d  = 1'b1;
      drop_d = clear_ovf ? 16'd1 : ((drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1);
    end else if (clear_ovf) begin
      ovf_d  = 1'b0;
      drop_d = 16'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mode_q       <= MODE_CONST;
      frame_q      <= 32'd0;
      ch_q         <= 3'd0;
      bi_q         <= 2'd0;
      csum_q       <= 8'h00;
      csum_phase_q <= 1'b0;
      ovf_q        <= 1'b0;
      drop_q       <= 16'd0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      frame_q      <= frame_d;
      ch_q         <= ch_d;
      bi_q         <= bi_d;
      csum_q       <= csum_d;
      csum_phase_q <= csum_phase_d;
      ovf_q        <= ovf_d;
      drop_q       <= drop_d;
    end
  end

  assign fifo_clk   = tick;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule
